// File: rtl/led_seq_ctrl_pkg.sv
// led_ctrl_pkg: shared types and constants for the LED sequencer.
// Holds the mode encoding and the button event bit positions.
package led_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_IDLE  = 2'd0,
      MODE_RUN   = 2'd1,
      MODE_PAUSE = 2'd2
   } mode_t;

   // Event vector bit positions; higher index wins on conflicts.
   localparam int EV_STEP  = 0;
   localparam int EV_START = 1;
   localparam int EV_PAUSE = 2;
   localparam int EV_CLEAR = 3;
   localparam int EV_N     = 4;

endpackage

// File: rtl/led_seq_ctrl_if.sv
// led_seq_ctrl_if: button levels in, tick/clear/mode/step_idx out.
// master = button/display side, slave = sequencer.
interface led_seq_ctrl_if;
   import led_ctrl_pkg::*;

   logic       start_btn;
   logic       pause_btn;
   logic       step_btn;
   logic       clear_btn;
   logic       tick;
   logic       clear;
   mode_t      mode;
   logic [2:0] step_idx;

   modport master (
      output start_btn, pause_btn, step_btn, clear_btn,
      input  tick, clear, mode, step_idx
   );

   modport slave (
      input  start_btn, pause_btn, step_btn, clear_btn,
      output tick, clear, mode, step_idx
   );

endinterface

// File: rtl/led_seq_ctrl_btn_event.sv
// btn_event: 2-FF synchronizer, optional debounce, rising-edge event.
// Ports: clk, reset_n (sync, low), btn (async level), evt (1-cycle).
// Macro CTRL_DEBOUNCE_EN adds a DB_CYCLES stable-time filter.
module btn_event
`ifdef CTRL_DEBOUNCE_EN
#(
   parameter int DB_CYCLES = 1000000
)
`endif
(
   input  logic clk,
   input  logic reset_n,
   input  logic btn,
   output logic evt
);

   logic s1;
   logic s2;
   logic lvl;
   logic prev;

   // Reset to 1 so a button held through reset never fires.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1   <= 1'b1;
         s2   <= 1'b1;
         prev <= 1'b1;
      end else begin
         s1   <= btn;
         s2   <= s1;
         prev <= lvl;
      end
   end

`ifdef CTRL_DEBOUNCE_EN
   localparam int DB_W = $clog2(DB_CYCLES + 1);

   logic [DB_W-1:0] db_cnt;
   logic            filt;

   // filt follows s2 only after DB_CYCLES consecutive differing cycles.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         filt   <= 1'b1;
         db_cnt <= '0;
      end else if (s2 == filt) begin
         db_cnt <= '0;
      end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
         filt   <= s2;
         db_cnt <= '0;
      end else begin
         db_cnt <= db_cnt + 1'b1;
      end
   end

   assign lvl = filt;
`else
   assign lvl = s2;
`endif

   assign evt = lvl & ~prev;

endmodule

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: run/pause/step sequencer with prescaled tick enable.
// Ports: clk, reset_n (sync, low), bus (led_seq_ctrl_if.slave).
// Macro CTRL_DEBOUNCE_EN enables per-button debounce in btn_event.
module led_seq_ctrl
   import led_ctrl_pkg::*;
#(
   parameter int DIV       = 25000000,
   parameter int CNT_W     = 25,
   parameter int LAST_IDX  = 7,
   parameter int DB_CYCLES = 1000000
)
(
   input  logic           clk,
   input  logic           reset_n,
   led_seq_ctrl_if.slave  bus
);

   localparam bit CFG_OK = (DIV >= 1) && (DB_CYCLES >= 1) &&
                           (LAST_IDX >= 0) && (LAST_IDX <= 7) &&
                           (((DIV - 1) >> CNT_W) == 0);

   if (!CFG_OK) begin : g_bad_cfg
      $error("led_seq_ctrl: illegal parameter set");
   end

   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DIV - 1);
   localparam logic [2:0]       LAST   = 3'(LAST_IDX);

   logic [EV_N-1:0] lvl;
   logic [EV_N-1:0] evt;

   assign lvl[EV_STEP]  = bus.step_btn;
   assign lvl[EV_START] = bus.start_btn;
   assign lvl[EV_PAUSE] = bus.pause_btn;
   assign lvl[EV_CLEAR] = bus.clear_btn;

   for (genvar i = 0; i < EV_N; i++) begin : g_btn
      btn_event
`ifdef CTRL_DEBOUNCE_EN
         #(.DB_CYCLES(DB_CYCLES))
`endif
         u_btn (
            .clk     (clk),
            .reset_n (reset_n),
            .btn     (lvl[i]),
            .evt     (evt[i])
         );
   end

   mode_t            state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             tick_q, tick_n;
   logic             clr_q, clr_n;
   logic [2:0]       idx, idx_n;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state  <= MODE_IDLE;
         cnt    <= RELOAD;
         tick_q <= 1'b0;
         clr_q  <= 1'b0;
         idx    <= '0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         tick_q <= tick_n;
         clr_q  <= clr_n;
         idx    <= idx_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      tick_n  = 1'b0;
      clr_n   = 1'b0;
      idx_n   = idx;
      if (evt[EV_CLEAR]) begin
         // Clear overrides everything, including a due tick.
         state_n = MODE_IDLE;
         cnt_n   = RELOAD;
         clr_n   = 1'b1;
         idx_n   = '0;
      end else begin
         unique case (state)
            MODE_IDLE: begin
               if (evt[EV_START]) begin
                  state_n = MODE_RUN;
                  cnt_n   = RELOAD;
               end
            end
            MODE_RUN: begin
               // Expiry still ticks on a pause edge; otherwise the
               // residual count is frozen for the resume.
               if (cnt == '0) begin
                  cnt_n  = RELOAD;
                  tick_n = 1'b1;
               end else if (!evt[EV_PAUSE]) begin
                  cnt_n = cnt - 1'b1;
               end
               if (evt[EV_PAUSE]) state_n = MODE_PAUSE;
            end
            MODE_PAUSE: begin
               if (evt[EV_START])     state_n = MODE_RUN;
               else if (evt[EV_STEP]) tick_n  = 1'b1;
            end
            default: state_n = MODE_IDLE;
         endcase
         if (tick_n) idx_n = (idx == LAST) ? 3'd0 : idx + 3'd1;
      end
   end

   assign bus.tick     = tick_q;
   assign bus.clear    = clr_q;
   assign bus.mode     = state;
   assign bus.step_idx = idx;

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
Run/pause/step sequencer for the LED pattern datapath. It replaces the free-running divided clock with a single-clock tick enable, and turns the four push-button levels into press events that drive a small FSM. Outputs are a one-cycle tick and clear pulse for the datapath, plus a mode code and step index for the 7-segment display. It sits between the inverted KEY inputs and the LED pattern/status blocks. All logic runs on the 50 MHz clock.

Parameters:
DIV, 25000000, clk cycles per tick in RUN (0.5 s at 50 MHz); legal range >= 1
CNT_W, 25, prescaler width; must satisfy 2^CNT_W > DIV-1
LAST_IDX, 7, highest step_idx value before wrap to 0
DB_CYCLES, 1000000, debounce stable-time in clk cycles (used only with the optional feature)

Ports:
clk  in  1  system clock (50 MHz)
reset_n  in  1  synchronous reset, active-low
start_btn  in  1  start/resume button, active-high level, asynchronous
pause_btn  in  1  pause button, active-high level, asynchronous
step_btn  in  1  single-step button, active-high level, asynchronous
clear_btn  in  1  clear button, active-high level, asynchronous
tick  out  1  one-cycle advance enable to the datapath
clear  out  1  one-cycle clear pulse to the datapath
mode  out  2  0=IDLE, 1=RUN, 2=PAUSE (3 never driven)
step_idx  out  3  tick count modulo LAST_IDX+1, for HEX display

Behaviour:
- Reset (reset_n low at a clk edge):
  - mode=IDLE, tick=0, clear=0, step_idx=0, prescaler=DIV-1.
  - All synchronizer and edge registers are set to 1, so a button held through reset produces no event.
- Button path, per button:
  - 2-FF synchronizer s1 then s2, followed by prev register.
  - Press event = s2 & ~prev.
  - Input high before edge k gives an event during the cycle after edge k+1. The FSM acts on that event at edge k+2.
  - A held button produces exactly one event.
- Event priority when several occur in the same cycle: clear > pause > start > step.
- FSM transitions:
  - IDLE: start goes to RUN and reloads the prescaler to DIV-1. pause and step are ignored.
  - RUN: pause goes to PAUSE; the prescaler holds its residual count. start and step are ignored.
  - PAUSE: start goes to RUN, resuming from the residual count with no reload. step asserts tick for exactly one cycle and mode stays PAUSE; the prescaler is untouched.
  - Any state: clear goes to IDLE, pulses clear for 1 cycle, sets step_idx=0 and reloads the prescaler.
- Prescaler:
  - Decrements only in RUN.
  - In RUN at count 0: reload to DIV-1 and register tick=1 for the next cycle.
  - DIV=1 gives tick every cycle in RUN.
- Expiry and pause in the same cycle: the tick is still issued and mode becomes PAUSE at the same edge.
- Expiry and clear in the same cycle: the tick is suppressed; clear wins.
- step_idx:
  - Increments on every tick, whether from the prescaler or from step.
  - Wraps LAST_IDX to 0.
  - Updates at the same edge tick is registered.
- tick and clear are registered outputs, never high for more than 1 consecutive cycle from a single event.
  - Exception: RUN with DIV=1, where tick is high continuously.
- Reset asserted mid-RUN: all outputs return to reset values at that edge. No pending tick survives.

Optional Feature:
Macro CTRL_DEBOUNCE_EN.
- Defined: each button adds a counter after s2. The filtered level changes only after s2 differs from it for DB_CYCLES consecutive cycles, and edge detection uses the filtered level. Press latency becomes DB_CYCLES+2 cycles. Pulses shorter than DB_CYCLES are discarded.
- Undefined: no counter and no filtering. s2 feeds the edge detector directly and DB_CYCLES is unused.

Decomposition:
- Package led_ctrl_pkg holds:
  - the 2-bit mode typedef;
  - constants MODE_IDLE, MODE_RUN, MODE_PAUSE;
  - event-priority bit positions.
- Sub-module btn_event holds the synchronizer, the optional debounce and the edge detector. It has ports clk, reset_n, btn, evt and is instantiated 4 times.
- FSM, prescaler and step_idx stay in led_seq_ctrl.

Test Plan:
Bench parameters: DIV=4, LAST_IDX=7, DB_CYCLES=4.
1. Reset, then start high 1 cycle -> mode=RUN 2 edges later; tick every 4th cycle; step_idx 0..7 then 0 on the 8th tick.
2. RUN, pause when prescaler=2 -> mode=PAUSE, no ticks for 50 cycles; start -> mode=RUN, first tick after 3 cycles (2,1,0), no reload.
3. PAUSE, step press -> exactly one tick, step_idx+1, mode stays 2; step press in IDLE -> no tick, step_idx unchanged.
4. RUN, clear and pause pressed in the same cycle -> mode=IDLE, clear high exactly 1 cycle, step_idx=0; then start -> full 4-cycle wait before first tick.
5. start held through reset release -> no event, mode stays IDLE. reset_n low for 1 cycle mid-RUN -> mode=0, tick=0, step_idx=0 at that edge.
6. With CTRL_DEBOUNCE_EN: start glitch of 3 cycles -> no event; held 6 cycles -> mode=RUN 6 edges after rise.
